// File: rtl/cdma_despreader_if.sv
// Chip-stream input and crossbar-facing output bundle of the CDMA despreader.
// The master side drives the chip stream; the slave side is the despreader.
interface cdma_despreader_if;
  logic [3:0] chip_in;
  logic       chip_valid;
  logic       sof;
  logic [3:0] data_out;
  logic [1:0] sel;
  logic       out_valid;
  logic       busy;

  modport master (
    output chip_in, chip_valid, sof,
    input  data_out, sel, out_valid, busy
  );

  modport slave (
    input  chip_in, chip_valid, sof,
    output data_out, sel, out_valid, busy
  );
endinterface

// File: rtl/cdma_despreader.sv
// Correlates a summed 4-chip Walsh stream against W0..W3, builds one nibble per
// user over a 16-chip frame, then emits the four nibbles one per cycle.
module cdma_despreader #(
  parameter int ACC_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  cdma_despreader_if.slave   bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                  state;
  logic [3:0]              cc;
  logic [3:0]              cur_cc;
  logic [1:0]              idx;
  logic signed [ACC_W-1:0] chip_ext;
  logic signed [ACC_W-1:0] acc     [4];
  logic signed [ACC_W-1:0] acc_nxt [4];
  logic [3:0]              nib     [4];
  logic [3:0]              nib_nxt [4];
  logic [3:0]              obuf    [4];
  logic [3:0]              data_q;
  logic [1:0]              sel_q;
  logic                    valid_q;

  assign chip_ext = {{(ACC_W-4){bus.chip_in[3]}}, bus.chip_in};
  // A start-of-frame chip is always chip 0, whatever the counter says.
  assign cur_cc   = bus.sof ? 4'd0 : cc;

  // NOTE: each always_comb target is fully assigned before any conditional
  // update, so no path leaves it holding a value and no latch is inferred.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      acc_nxt[k] = (cur_cc[1:0] == 2'd0) ? '0 : acc[k];
      // Wk[c] is negative exactly when (k & c) has odd parity.
      if (^(2'(k) & cur_cc[1:0])) acc_nxt[k] = acc_nxt[k] - chip_ext;
      else                        acc_nxt[k] = acc_nxt[k] + chip_ext;
      nib_nxt[k] = bus.sof ? 4'd0 : nib[k];
      if (cur_cc[1:0] == 2'd3)
        nib_nxt[k][~cur_cc[3:2]] = !acc_nxt[k][ACC_W-1] && (acc_nxt[k] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cc      <= '0;
      idx     <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      // NOTE: these small arrays are flops, not RAM, so resetting them is
      // cheap and guarantees clean nibbles for the first frame after reset.
      for (int k = 0; k < 4; k++) begin
        acc[k]  <= '0;
        nib[k]  <= '0;
        obuf[k] <= '0;
      end
    end else begin
      if (state == EMIT) begin
        if (idx == 2'd3) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          sel_q   <= '0;
          data_q  <= '0;
        end else begin
          idx    <= idx + 2'd1;
          sel_q  <= idx + 2'd1;
          data_q <= obuf[idx + 2'd1];
        end
      end

      if (bus.chip_valid) begin
        cc <= cur_cc + 4'd1;
        for (int k = 0; k < 4; k++) begin
          acc[k] <= acc_nxt[k];
          nib[k] <= nib_nxt[k];
        end
        // Frame complete: latch all nibbles and present user 0 next cycle.
        if (cur_cc == 4'd15) begin
          for (int k = 0; k < 4; k++) obuf[k] <= nib_nxt[k];
          state   <= EMIT;
          idx     <= '0;
          sel_q   <= '0;
          data_q  <= nib_nxt[0];
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state == EMIT);

endmodule

// File: tb/tb_cdma_despreader.sv
// Randomized bench for cdma_despreader: frames are decoded by a Walsh-correlation
// model and the emitted nibble sequence and its timing are compared per user.
module tb_cdma_despreader;

  typedef int         frame_t [16];
  typedef logic [3:0] nibs_t  [4];
  typedef struct { int cyc; int sel; int data; int busy; } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  obs_t obs_q [$];
  int   anom_q [$];
  int   walsh [4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};

  cdma_despreader_if bus ();

  cdma_despreader #(.ACC_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every emitted beat, and any non-zero output while not emitting.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1)
      obs_q.push_back('{cyc, int'(bus.sel), int'(bus.data_out), int'(bus.busy)});
    else if (bus.busy !== 1'b0 || bus.sel !== 2'd0 || bus.data_out !== 4'd0)
      anom_q.push_back(cyc);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: correlate each symbol with each Walsh code, bit = (sum > 0), MSB first.
  function automatic nibs_t model(input frame_t ch);
    nibs_t n;
    int    sum;
    for (int k = 0; k < 4; k++) begin
      n[k] = 4'd0;
      for (int s = 0; s < 4; s++) begin
        sum = 0;
        for (int c = 0; c < 4; c++) sum += ch[4*s+c] * walsh[k][c];
        n[k][3-s] = (sum > 0);
      end
    end
    return n;
  endfunction

  // Transmit model: chip = sum over users of (2b-1) * Wk[c].
  function automatic frame_t encode(input nibs_t b);
    frame_t ch;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++) begin
        ch[4*s+c] = 0;
        for (int k = 0; k < 4; k++)
          ch[4*s+c] += (b[k][3-s] ? 1 : -1) * walsh[k][c];
      end
    return ch;
  endfunction

  function automatic frame_t repeat_symbol(input int a, input int b, input int c, input int d);
    frame_t ch;
    for (int s = 0; s < 4; s++) begin
      ch[4*s] = a; ch[4*s+1] = b; ch[4*s+2] = c; ch[4*s+3] = d;
    end
    return ch;
  endfunction

  function automatic nibs_t rand_nibs();
    nibs_t n;
    for (int k = 0; k < 4; k++) n[k] = 4'($urandom_range(15));
    return n;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.chip_valid = 1'b0;
      bus.sof        = 1'($urandom_range(1));
      bus.chip_in    = 4'($urandom_range(15));
    end
  endtask

  task automatic send_frame(input frame_t ch, input bit with_sof, input bit gaps, output int t_last);
    for (int i = 0; i < 16; i++) begin
      if (gaps && i > 0) idle(1);
      @(negedge clk);
      bus.chip_valid = 1'b1;
      bus.sof        = with_sof && (i == 0);
      bus.chip_in    = 4'(ch[i]);
      @(posedge clk);
      #1 t_last = cyc;
    end
  endtask

  task automatic expect_emis(input string name, input int t0, input nibs_t exp);
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL %s user%0d missing, want cyc=%0d data=%h", name, i, t0 + i, exp[i]);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc != t0 + i || o.sel != i || o.data != int'(exp[i]) || o.busy != 1) begin
          bad++;
          $display("FAIL %s user%0d got cyc=%0d sel=%0d data=%h busy=%0d want cyc=%0d sel=%0d data=%h busy=1",
                   name, i, o.cyc, o.sel, o.data, o.busy, t0 + i, i, exp[i]);
        end
      end
    end
  endtask

  task automatic expect_quiet(input string name);
    total++;
    if (obs_q.size() != 0 || anom_q.size() != 0) begin
      bad++;
      $display("FAIL %s extra_beats=%0d idle_anomalies=%0d want 0/0", name, obs_q.size(), anom_q.size());
    end
    obs_q.delete();
    anom_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bus.chip_valid = 1'($urandom_range(1));
      bus.chip_in    = 4'($urandom_range(15));
      bus.sof        = 1'($urandom_range(1));
      #1;
      total++;
      if ({bus.out_valid, bus.busy, bus.sel, bus.data_out} !== 8'h00) begin
        bad++;
        $display("FAIL reset_outputs got valid=%b busy=%b sel=%0d data=%h want all 0",
                 bus.out_valid, bus.busy, bus.sel, bus.data_out);
      end
    end
    obs_q.delete();
    anom_q.delete();
    @(negedge clk);
    bus.chip_valid = 1'b0;
    rst_n = 1'b1;
    idle(20);
    expect_quiet("reset_idle");
  endtask

  task automatic test_all_ones();
    int t;
    send_frame(repeat_symbol(4, 0, 0, 0), 1'b1, 1'b0, t);
    idle(8);
    expect_emis("all_ones", t, '{4'hF, 4'hF, 4'hF, 4'hF});
    expect_quiet("all_ones_len");
  endtask

  task automatic test_single_user();
    int     t;
    frame_t ch;
    send_frame(repeat_symbol(-2, 2, -2, -2), 1'b1, 1'b0, t);
    idle(6);
    expect_emis("single_user", t, '{4'h0, 4'h0, 4'hF, 4'h0});
    ch = repeat_symbol(-4, 0, 0, 0);
    ch[0] = -2; ch[1] = 2; ch[2] = -2; ch[3] = -2;
    send_frame(ch, 1'b1, 1'b0, t);
    idle(6);
    expect_emis("mixed_msb", t, '{4'h0, 4'h0, 4'h8, 4'h0});
    expect_quiet("single_user_len");
  endtask

  task automatic test_tie_gaps();
    int t;
    send_frame(repeat_symbol(0, 0, 0, 0), 1'b1, 1'b1, t);
    idle(8);
    expect_emis("tie_gaps", t, '{4'h0, 4'h0, 4'h0, 4'h0});
    expect_quiet("tie_gaps_len");
  endtask

  task automatic test_resync();
    int     t, ta, tb;
    frame_t fa, fb;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.chip_valid = 1'b1;
      bus.sof        = 1'b0;
      bus.chip_in    = 4'($urandom_range(15));
    end
    send_frame(repeat_symbol(4, 0, 0, 0), 1'b1, 1'b0, t);
    idle(8);
    expect_emis("resync", t, '{4'hF, 4'hF, 4'hF, 4'hF});
    expect_quiet("resync_once");
    fa = encode(rand_nibs());
    fb = encode(rand_nibs());
    send_frame(fa, 1'b1, 1'b0, ta);
    send_frame(fb, 1'b1, 1'b0, tb);
    idle(8);
    expect_emis("b2b_first", ta, model(fa));
    expect_emis("b2b_second", ta + 16, model(fb));
    expect_quiet("b2b_len");
  endtask

  task automatic test_reset_mid();
    int     t;
    frame_t ch;
    send_frame(encode(rand_nibs()), 1'b1, 1'b0, t);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.sel !== 2'd0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got valid=%b sel=%0d busy=%b want 0/0/0", bus.out_valid, bus.sel, bus.busy);
    end
    idle(2);
    rst_n = 1'b1;
    idle(6);
    total++;
    if (obs_q.size() != 2 || obs_q[obs_q.size()-1].sel != 1) begin
      bad++;
      $display("FAIL reset_abandon got beats=%0d want 2 ending at sel=1", obs_q.size());
    end
    obs_q.delete();
    anom_q.delete();
    ch = encode(rand_nibs());
    send_frame(ch, 1'b0, 1'b0, t);
    idle(6);
    expect_emis("after_reset", t, model(ch));
    expect_quiet("after_reset_len");
  endtask

  task automatic test_random_chips();
    int     t;
    frame_t ch;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 16; i++) ch[i] = int'($urandom_range(15)) - 8;
      send_frame(ch, 1'($urandom_range(1)), 1'($urandom_range(1)), t);
      idle(6);
      expect_emis("random_chips", t, model(ch));
    end
    expect_quiet("random_chips_len");
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.chip_valid = 1'b0;
    bus.sof        = 1'b0;
    bus.chip_in    = 4'd0;
    test_reset();
    test_all_ones();
    test_single_user();
    test_tie_gaps();
    test_resync();
    test_reset_mid();
    test_random_chips();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdma_despreader.md
# cdma_despreader

Front-end stage of the CDMA router that feeds the 4-user output crossbar. It receives a serial stream of summed 4-chip Walsh-spread chips and correlates each chip against the four length-4 Walsh codes to recover one bit per user per symbol. After every 4-symbol frame it has one 4-bit nibble per user, and it presents those nibbles to the crossbar one per cycle as `data_out` plus a `sel` user index.

## Interface
- `ACC_W`, default 6: signed correlator accumulator width. The minimum is 6 (4 × 4-bit signed chip).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `chip_in` in 4: two's-complement summed chip, nominal range −4..+4. Any 4-bit value is accepted arithmetically.
- `chip_valid` in 1: `chip_in` is sampled on this edge.
- `sof` in 1: start of frame, qualified by `chip_valid`. The current chip is chip 0 of a new frame.
- `data_out` out 4: recovered nibble for user `sel`. Drives the crossbar `data_in`.
- `sel` out 2: destination user index 0..3. Drives the crossbar `sel`.
- `out_valid` out 1: `data_out`/`sel` are valid this cycle.
- `busy` out 1: emission in progress (high whenever the state is EMIT).

## Operation
- **Walsh codes**, applied per chip index c = 0..3 within a symbol:
  - W0 = + + + +
  - W1 = + − + −
  - W2 = + + − −
  - W3 = + − − +
- **Transmit model:** chip = Σk (2·bk − 1)·Wk[c].
- **Chip counter** `cc[3:0]`:
  - Counts accepted chips 0..15 per frame. `cc[1:0]` is the chip-within-symbol; `cc[3:2]` is the symbol index s.
  - When `chip_valid` and `sof` are both high, the current chip is treated as cc = 0: accumulators restart from this chip and any partial frame and partial nibbles are discarded.
  - When `chip_valid` is low, nothing changes.
- **Correlators:** four signed `ACC_W`-bit accumulators.
  - At cc[1:0] = 0: acck ← ±chip_in.
  - Otherwise: acck ← acck ± chip_in, with the sign taken from Wk[cc[1:0]].
  - Chip_in is sign-extended before the add. Overflow is impossible: the worst case is 4 × (−8) = −32.
- **Decision** at chip cc[1:0] = 3, using acck plus the current contribution:
  - bit = 1 if the result is > 0.
  - bit = 0 if the result is ≤ 0 (a tie resolves to 0).
  - The bit is written to nibblek[3 − s], so the first symbol of the frame is the MSB.
- **Frame completion:** on the edge that accepts cc = 15, all four completed nibbles (including the symbol-3 bits) are copied into the output buffer `obuf[0..3]`. The FSM enters EMIT with idx = 0, and cc wraps to 0.
- **FSM:**
  - IDLE: `out_valid` = 0, `data_out` = 0, `sel` = 0.
  - EMIT: `out_valid` = 1, `sel` = idx, `data_out` = obuf[idx].
    - idx < 3: idx ← idx + 1.
    - idx = 3: return to IDLE.
- **Concurrency:** chip acceptance and correlation for the next frame continue during EMIT. A frame needs ≥ 16 cycles and EMIT lasts 4, so the output buffer is never overwritten mid-emission and no overrun logic is needed.
- **Reset values**, all asynchronous on `rst_n` low, including mid-EMIT (the emission is abandoned):
  - `cc` = 0, all accumulators = 0, nibbles = 0, `obuf` = 0.
  - State = IDLE.
  - `out_valid` = 0, `data_out` = 0, `sel` = 0, `busy` = 0.
  - After reset, the first accepted chip is cc = 0 even without `sof`.

## Timing
- All outputs are registered.
- Latency: `out_valid` rises in the cycle immediately after the edge that accepts chip 15. User 0 appears in that cycle, then users 1, 2, 3 in the next three consecutive cycles. `busy` tracks `out_valid`.
- `chip_valid` may be high every cycle (back-to-back frames). The next frame's EMIT starts exactly 16 accepted chips after the previous one.
- Gaps in `chip_valid` stretch the frame but never affect an EMIT already in progress.
- A `sof` arriving during EMIT restarts only the correlation path. Emission of the buffered frame completes normally.

## Test plan
1. **Reset values:** hold `rst_n` low with random `chip_in`/`chip_valid`. Expect `out_valid`, `data_out`, `sel`, `busy` all 0. Release reset and leave `chip_valid` low for 20 cycles: expect `out_valid` to stay 0.
2. **All-ones frame:** `sof` on the first chip, then chips (4, 0, 0, 0) ×4 symbols, back-to-back. The cycle after chip 15, expect `sel` = 0,1,2,3 with `data_out` = 4'b1111 each and `out_valid` high for exactly 4 cycles.
3. **Single-user frame:** chips (−2, 2, −2, −2) ×4. Expect user 2 → 1111 and users 0, 1, 3 → 0000. Then a mixed frame where symbol 0 is only user 2 and symbols 1–3 are all-zero (chips (−4, 0, 0, 0)): expect user 2 → 4'b1000.
4. **Tie and gaps:** chips (0, 0, 0, 0) ×4 with `chip_valid` toggling every other cycle. Expect all four nibbles 0000, and `out_valid` to rise one cycle after the 16th accepted chip.
5. **Resync:** send 7 chips, then assert `sof` with a full all-ones frame. Expect exactly one emission, of 1111 ×4, 16 accepted chips after the `sof` chip. Then send back-to-back frames with `sof` during EMIT: expect both emissions intact, 16 cycles apart.
6. **Reset mid-operation:** assert `rst_n` low during the EMIT cycle where `sel` = 1. Expect `out_valid` = 0 and `sel` = 0 immediately (asynchronous), and no remaining users emitted. The next full frame decodes correctly.
